// File: rtl/doc_wave_mem.sv
// doc_wave_mem: DOC5503 wave-RAM responder with host byte access, both arbitrated
// onto a single RAM port (wave fetch beats a pending host slot when idle).
module doc_wave_mem #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [ADDR_WIDTH-1:0] wave_address_i,
    input  logic                  wave_rd_i,
    output logic                  wave_data_ready_o,
    output logic [7:0]            wave_data_o,
    input  logic [ADDR_WIDTH-1:0] host_addr_i,
    input  logic [7:0]            host_data_i,
    input  logic                  host_we_i,
    input  logic                  host_rd_i,
    output logic [7:0]            host_data_o,
    output logic                  host_valid_o,
    output logic                  host_busy_o,
    output logic                  host_overrun_o
);
    typedef enum logic [1:0] {IDLE, WAVE, HOST} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  armed_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  slot_we_q;
    logic [ADDR_WIDTH-1:0] slot_addr_q;
    logic [7:0]            slot_data_q;
    logic                  ready_q;
    logic                  valid_q;
    logic [7:0]            wave_data_q;
    logic [7:0]            host_data_q;
    logic [7:0]            rdata_q;
    logic [7:0]            mem [0:(1<<ADDR_WIDTH)-1];

    logic                  wave_go;
    logic                  host_go;
    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;

    assign wave_go  = (state_q == IDLE) && wave_rd_i && armed_q;
    assign host_go  = (state_q == IDLE) && !wave_go && busy_q;
    assign mem_addr = wave_go ? wave_address_i : slot_addr_q;
    assign mem_re   = wave_go || (host_go && !slot_we_q);
    assign mem_we   = (state_q == HOST) && slot_we_q;

    // Single RAM port: reads are issued on the IDLE transition, host writes commit in HOST.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[slot_addr_q] <= slot_data_q;
        if (mem_re) rdata_q <= mem[mem_addr];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            armed_q     <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            slot_we_q   <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            wave_data_q <= '0;
            host_data_q <= '0;
        end else begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            // Re-arm only once rd is seen low, so a held rd yields a single fetch.
            if (!wave_rd_i) armed_q <= 1'b1;
            else if (wave_go) armed_q <= 1'b0;
            if (host_we_i || host_rd_i) begin
                if (busy_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    busy_q      <= 1'b1;
                    slot_we_q   <= host_we_i;
                    slot_addr_q <= host_addr_i;
                    slot_data_q <= host_data_i;
                end
            end
            case (state_q)
                IDLE: begin
                    if (wave_go) begin
                        cnt_q   <= 4'(READ_LATENCY - 1);
                        state_q <= WAVE;
                    end else if (busy_q) begin
                        state_q <= HOST;
                    end
                end
                WAVE: begin
                    if (cnt_q == 4'd0) begin
                        wave_data_q <= rdata_q;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOST: begin
                    if (!slot_we_q) begin
                        host_data_q <= rdata_q;
                        valid_q     <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wave_data_ready_o = ready_q;
    assign wave_data_o       = wave_data_q;
    assign host_data_o       = host_data_q;
    assign host_valid_o      = valid_q;
    assign host_busy_o       = busy_q;
    assign host_overrun_o    = overrun_q;
endmodule

// File: tb/tb_doc_wave_mem.sv
// tb_doc_wave_mem: three instances (latency 2, 1, 15) on shared stimulus, checked by a
// queue scoreboard against an address->byte model of the sound RAM.
module tb_doc_wave_mem;
    localparam int N = 3;

    function automatic int lat(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  w_addr = '0;
    logic         w_rd = 1'b0;
    logic [15:0]  h_addr = '0;
    logic [7:0]   h_data = '0;
    logic         h_we = 1'b0;
    logic         h_rd = 1'b0;
    logic [N-1:0] rdy, vld, busy, ovr;
    logic [7:0]   wd [N];
    logic [7:0]   hd [N];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    exp_t         wq [N][$];
    exp_t         hq [N][$];
    logic [7:0]   model [int];
    logic [15:0]  pool [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < N; k++) begin : g_dut
        doc_wave_mem #(.ADDR_WIDTH(16), .READ_LATENCY(lat(k))) u_dut (
            .clk_i            (clk),
            .reset_n_i        (rst_n),
            .wave_address_i   (w_addr),
            .wave_rd_i        (w_rd),
            .wave_data_ready_o(rdy[k]),
            .wave_data_o      (wd[k]),
            .host_addr_i      (h_addr),
            .host_data_i      (h_data),
            .host_we_i        (h_we),
            .host_rd_i        (h_rd),
            .host_data_o      (hd[k]),
            .host_valid_o     (vld[k]),
            .host_busy_o      (busy[k]),
            .host_overrun_o   (ovr[k])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (wq[k].size() != 0 || hq[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_zero();
        if (rdy != 0 || vld != 0 || busy != 0 || ovr != 0) return 1'b0;
        for (int k = 0; k < N; k++) if (wd[k] != 0 || hd[k] != 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (rdy[k]) begin
                if (wq[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wave_unexpected inst%0d: got pulse data %0h expected no pulse", k, wd[k]);
                end else begin
                    e = wq[k].pop_front();
                    chk($sformatf("wave_data inst%0d", k), 32'(wd[k]), 32'(e.d));
                    chk($sformatf("wave_cycle inst%0d", k), cyc, e.due);
                end
            end
            if (vld[k]) begin
                if (hq[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL host_unexpected inst%0d: got pulse data %0h expected no pulse", k, hd[k]);
                end else begin
                    e = hq[k].pop_front();
                    chk($sformatf("host_data inst%0d", k), 32'(hd[k]), 32'(e.d));
                    chk($sformatf("host_cycle inst%0d", k), cyc, e.due);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (busy == 0 && all_empty()) return;
        end
        total++;
        bad++;
        $display("FAIL wait_idle: got still busy/pending expected idle within 300 cycles");
    endtask

    task automatic host_op(input logic we, input logic rd, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        h_we = we;
        h_rd = rd;
        h_addr = a;
        h_data = d;
        if (we) model[int'(a)] = d;
        else if (rd) for (int k = 0; k < N; k++) hq[k].push_back('{model[int'(a)], cyc + 3});
        @(negedge clk);
        h_we = 1'b0;
        h_rd = 1'b0;
        chk("busy_after_capture", 32'(busy), 32'(3'b111));
        wait_idle();
    endtask

    task automatic wave_op(input logic [15:0] a);
        @(negedge clk);
        w_rd = 1'b1;
        w_addr = a;
        for (int k = 0; k < N; k++) wq[k].push_back('{model[int'(a)], cyc + 1 + lat(k)});
        wait_idle();
        @(negedge clk);
        w_rd = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", 32'(all_zero()), 32'd1);
        rst_n = 1'b1;

        host_op(1'b1, 1'b0, 16'h1234, 8'h5A);
        host_op(1'b0, 1'b1, 16'h1234, 8'h00);
        host_op(1'b1, 1'b0, 16'h0100, 8'h80);
        wave_op(16'h0100);

        // rd held well past every instance's ready: one pulse each
        @(negedge clk);
        w_rd = 1'b1;
        w_addr = 16'h0100;
        for (int k = 0; k < N; k++) wq[k].push_back('{model[32'h0100], cyc + 1 + lat(k)});
        repeat (20) @(negedge clk);
        #1;
        chk("hold_pending_empty", 32'(all_empty()), 32'd1);
        w_rd = 1'b0;
        @(negedge clk);
        w_rd = 1'b1;
        for (int k = 0; k < N; k++) wq[k].push_back('{model[32'h0100], cyc + 1 + lat(k)});
        wait_idle();
        @(negedge clk);
        w_rd = 1'b0;

        // same-cycle host write and wave fetch of one address: fetch sees old byte
        host_op(1'b1, 1'b0, 16'h2222, 8'h11);
        @(negedge clk);
        w_rd = 1'b1;
        w_addr = 16'h2222;
        h_we = 1'b1;
        h_addr = 16'h2222;
        h_data = 8'h99;
        for (int k = 0; k < N; k++) wq[k].push_back('{8'h11, cyc + 1 + lat(k)});
        model[32'h2222] = 8'h99;
        @(negedge clk);
        h_we = 1'b0;
        for (int i = 0; i < 40 && !all_empty(); i++) begin
            @(negedge clk);
            #1;
            for (int k = 0; k < N; k++) if (rdy[k]) chk($sformatf("busy_at_wave_ready inst%0d", k), 32'(busy[k]), 32'd1);
        end
        wait_idle();
        @(negedge clk);
        w_rd = 1'b0;
        host_op(1'b0, 1'b1, 16'h2222, 8'h00);

        // write and read strobes together: write wins, no read pulse
        host_op(1'b1, 1'b1, 16'h3333, 8'h77);
        host_op(1'b0, 1'b1, 16'h3333, 8'h00);

        chk("overrun_clear_before", 32'(ovr), 32'd0);
        @(negedge clk);
        h_we = 1'b1;
        h_addr = 16'h4444;
        h_data = 8'h21;
        model[32'h4444] = 8'h21;
        @(negedge clk);
        h_data = 8'h42;
        @(negedge clk);
        h_we = 1'b0;
        #1;
        chk("overrun_set", 32'(ovr), 32'(3'b111));
        wait_idle();
        host_op(1'b0, 1'b1, 16'h4444, 8'h00);
        chk("overrun_sticky", 32'(ovr), 32'(3'b111));

        pool[0] = 16'h0000;
        pool[1] = 16'hFFFF;
        for (int i = 2; i < 8; i++) pool[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) host_op(1'b1, 1'b0, pool[i], 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            int op;
            a = pool[$urandom_range(0, 7)];
            op = $urandom_range(0, 2);
            if (op == 0) host_op(1'b1, 1'b0, a, 8'($urandom));
            else if (op == 1) host_op(1'b0, 1'b1, a, 8'h00);
            else wave_op(a);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset while every instance sits in WAVE
        @(negedge clk);
        w_rd = 1'b1;
        w_addr = 16'h1234;
        @(negedge clk);
        rst_n = 1'b0;
        w_rd = 1'b0;
        #1;
        chk("midwave_reset_outputs_zero", 32'(all_zero()), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("after_reset_outputs_zero", 32'(all_zero()), 32'd1);
        host_op(1'b0, 1'b1, 16'h1234, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
